// File: rtl/sipo_shift_reg.sv
// Serial-in, parallel-out shift register with word-boundary tracking.
// A bit counter and a one-cycle word_valid pulse mark each completed WIDTH-bit word.
module sipo_shift_reg #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned CW       = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic [CW-1:0]    bit_count,
  output logic             word_valid
);

  logic [WIDTH-1:0] shift_nxt;
  logic             last_bit;

  // New bit enters at bit 0 (MSB first) or at bit WIDTH-1 (LSB first)
  always_comb begin
    shift_nxt = parallel_out;
    if (MSB_FIRST) begin
      shift_nxt = {parallel_out[WIDTH-2:0], serial_in};
    end else begin
      shift_nxt = {serial_in, parallel_out[WIDTH-1:1]};
    end
  end

  assign last_bit = (bit_count == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parallel_out <= '0;
      bit_count    <= '0;
      word_valid   <= 1'b0;
    end else begin
      parallel_out <= shift_nxt;
      if (last_bit) begin
        bit_count  <= '0;
        word_valid <= 1'b1;
      end else begin
        bit_count  <= bit_count + CW'(1);
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_shift_reg.sv
// Bench for sipo_shift_reg: three configurations share one serial stream and are
// compared against a bit-history model after every clock edge.
module tb_sipo_shift_reg;

  logic clk;
  logic rst;
  logic serial_in;

  logic [3:0] po_a;  logic [1:0] bc_a;  logic wv_a;   // WIDTH=4, MSB first
  logic [3:0] po_b;  logic [1:0] bc_b;  logic wv_b;   // WIDTH=4, LSB first
  logic [7:0] po_c;  logic [2:0] bc_c;  logic wv_c;   // WIDTH=8, MSB first

  int tests;
  int fails;
  bit hist[$];

  sipo_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .serial_in(serial_in),
    .parallel_out(po_a), .bit_count(bc_a), .word_valid(wv_a));
  sipo_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst), .serial_in(serial_in),
    .parallel_out(po_b), .bit_count(bc_b), .word_valid(wv_b));
  sipo_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst(rst), .serial_in(serial_in),
    .parallel_out(po_c), .bit_count(bc_c), .word_valid(wv_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Last w bits received since reset; most recent at bit 0 (msb) or bit w-1 (lsb)
  function automatic logic [63:0] exp_po(input int w, input bit msb);
    logic [63:0] r;
    int n;
    r = '0;
    n = hist.size();
    for (int k = 0; k < w && k < n; k++) begin
      if (msb) r[k] = hist[n-1-k];
      else     r[w-1-k] = hist[n-1-k];
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_bc(input int w);
    return 64'(hist.size() % w);
  endfunction

  function automatic logic [63:0] exp_wv(input int w);
    return 64'((hist.size() > 0) && (hist.size() % w == 0));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".a.po"}, 64'(po_a), exp_po(4, 1'b1));
    chk({tag, ".a.bc"}, 64'(bc_a), exp_bc(4));
    chk({tag, ".a.wv"}, 64'(wv_a), exp_wv(4));
    chk({tag, ".b.po"}, 64'(po_b), exp_po(4, 1'b0));
    chk({tag, ".b.bc"}, 64'(bc_b), exp_bc(4));
    chk({tag, ".b.wv"}, 64'(wv_b), exp_wv(4));
    chk({tag, ".c.po"}, 64'(po_c), exp_po(8, 1'b1));
    chk({tag, ".c.bc"}, 64'(bc_c), exp_bc(8));
    chk({tag, ".c.wv"}, 64'(wv_c), exp_wv(8));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".a"}, {po_a, bc_a, wv_a}, 64'd0);
    chk({tag, ".b"}, {po_b, bc_b, wv_b}, 64'd0);
    chk({tag, ".c"}, {po_c, bc_c, wv_c}, 64'd0);
  endtask

  // Called just after an edge; drives the bit for the next edge and checks after it
  task automatic step(input bit b, input string tag);
    serial_in = b;
    @(posedge clk);
    #1;
    hist.push_back(b);
    check_model(tag);
  endtask

  // Asynchronous reset mid-cycle, held across one edge
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    check_zero({tag, ".async"});
    serial_in = 1'b1;
    @(posedge clk);
    #1;
    check_zero({tag, ".held"});
    hist.delete();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] seq4;
    logic [3:0] exp_a4  [4];
    logic [3:0] exp_b4  [4];
    logic [1:0] exp_bc4 [4];
    logic [7:0] byte_a5;
    int pulses;
    int last_pulse;

    tests = 0;
    fails = 0;
    rst = 1'b1;
    serial_in = 1'b0;

    // Reset from time zero, released after the first edge
    #2;
    check_zero("por");
    @(posedge clk);
    #1;
    check_zero("por_held");
    rst = 1'b0;

    // Directed 1,0,1,0 on both WIDTH=4 orientations
    seq4 = 4'b1010;
    exp_a4  = '{4'b0001, 4'b0010, 4'b0101, 4'b1010};
    exp_b4  = '{4'b1000, 4'b0100, 4'b1010, 4'b0101};
    exp_bc4 = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      step(seq4[3-i], "dir1010");
      chk("dir1010.a.po_const", 64'(po_a), 64'(exp_a4[i]));
      chk("dir1010.b.po_const", 64'(po_b), 64'(exp_b4[i]));
      chk("dir1010.a.bc_const", 64'(bc_a), 64'(exp_bc4[i]));
      chk("dir1010.a.wv_const", 64'(wv_a), 64'(i == 3));
    end
    step(1'b1, "dir1010_after");

    // Asynchronous reset with nonzero contents
    do_reset("rst_mid_cycle");

    // Twelve-bit stream: three pulses, four clocks apart
    pulses = 0;
    last_pulse = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'($urandom_range(1)), "stream12");
      if (wv_a) begin
        if (pulses > 0) chk("stream12.spacing", 64'(i - last_pulse), 64'd4);
        pulses++;
        last_pulse = i;
      end
    end
    chk("stream12.pulses", 64'(pulses), 64'd3);

    // Reset mid-word discards the partial word
    do_reset("rst_pre_word");
    step(1'b1, "midword_pre");
    step(1'b1, "midword_pre");
    do_reset("rst_midword");
    seq4 = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      step(seq4[3-i], "midword_post");
      chk("midword_post.wv_const", 64'(wv_a), 64'(i == 3));
    end
    chk("midword_post.po_const", 64'(po_a), 64'h9);

    // Reset on the edge that would complete a word suppresses word_valid
    do_reset("rst_pre_cancel");
    for (int i = 0; i < 3; i++) step(1'b1, "cancel_pre");
    do_reset("rst_cancel");
    chk("cancel.wv", 64'(wv_a), 64'd0);

    // 0xA5 MSB first on the WIDTH=8 instance, then one more bit
    byte_a5 = 8'hA5;
    for (int i = 0; i < 8; i++) step(byte_a5[7-i], "byte_a5");
    chk("byte_a5.po_const", 64'(po_c), 64'hA5);
    chk("byte_a5.wv_const", 64'(wv_c), 64'd1);
    step(1'b1, "byte_4b");
    chk("byte_4b.po_const", 64'(po_c), 64'h4B);
    chk("byte_4b.wv_const", 64'(wv_c), 64'd0);

    // Random stream with occasional resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(24) == 0) do_reset("rnd_rst");
      else step(1'($urandom_range(1)), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sipo_shift_reg.md
Name: sipo_shift_reg

Overview:
- Serial-in, parallel-out shift register.
- Captures one bit from serial_in on every rising clock edge and presents the most recent WIDTH bits on parallel_out.
- Used as the front end of serial receive paths: a word-assembly stage ahead of parallel consumers.
- Word-boundary outputs (bit counter, word-valid pulse) let downstream logic know when a full word has been shifted in.

Parameters:
- WIDTH, 4, number of bits in parallel_out; legal range 2..64.
- MSB_FIRST, 1:
  - 1: each new bit enters at bit 0 and existing bits move toward the MSB (shift left), so the first-received bit ends in bit WIDTH-1.
  - 0: each new bit enters at bit WIDTH-1 and existing bits move toward bit 0 (shift right).

Ports:
- clk  input  1  rising-edge clock; the single clock of the block.
- rst  input  1  asynchronous, active-high reset.
- serial_in  input  1  serial data bit, sampled on every rising edge of clk.
- parallel_out  output  WIDTH  current shift register contents, registered.
- bit_count  output  CW  bits received in the current word, 0..WIDTH-1, with CW = max(1, clog2(WIDTH)).
- word_valid  output  1  one-cycle pulse, high in the cycle after the WIDTH-th bit of a word is captured.

Behaviour:
- Reset:
  - rst high forces parallel_out = 0, bit_count = 0 and word_valid = 0 immediately, without waiting for a clock edge.
  - Outputs hold these values while rst is high; no shifting occurs.
- Release: the first rising edge with rst low captures the first bit.
- Shift, MSB_FIRST=1: parallel_out <= {parallel_out[WIDTH-2:0], serial_in}.
- Shift, MSB_FIRST=0: parallel_out <= {serial_in, parallel_out[WIDTH-1:1]}.
- Shifting is unconditional every clock with rst low; there is no enable and no hold state.
- Latency: the bit sampled at edge N is visible on parallel_out right after edge N, i.e. one-edge latency. A bit falls off the far end after WIDTH further edges.
- bit_count:
  - Increments on every capture and wraps from WIDTH-1 to 0.
  - The edge that captures the WIDTH-th bit of a word sets bit_count to 0 and word_valid to 1.
- word_valid:
  - Set by that edge, deasserted by the next edge.
  - Pulses exactly once every WIDTH clocks in continuous operation.
  - At the word_valid cycle, parallel_out holds exactly the last WIDTH bits received, aligned per MSB_FIRST.
- Reset mid-word: the partial word is discarded, bit_count returns to 0 and any pending word_valid pulse is cancelled. The next word starts with the first post-reset bit.
- Reset asserted in the same cycle word_valid would rise: reset wins and word_valid stays 0.
- serial_in = X/Z: propagates into parallel_out unfiltered. Counters are unaffected.
- Only registers drive the outputs; no combinational path exists from serial_in to any output.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle with parallel_out nonzero -> parallel_out=0, bit_count=0 and word_valid=0 before the next clk edge.
- Default shift, 10 ns clock with rising edges at 5/15/25/35 ns, serial_in 1,0,1,0 presented before each edge -> parallel_out 0001, 0010, 0101, 1010. bit_count 1, 2, 3, 0. word_valid high only in the cycle after the 35 ns edge.
- MSB_FIRST=0, WIDTH=4, same stimulus 1,0,1,0 -> parallel_out 1000, 0100, 1010, 0101.
- Continuous stream of 12 bits, WIDTH=4 -> word_valid pulses exactly 3 times, 4 clocks apart. Each pulse shows the corresponding 4-bit group on parallel_out.
- Reset mid-word: shift in 1,1, pulse rst, then shift in 1,0,0,1 -> no word_valid before the 4th post-reset bit, then parallel_out=1001 with word_valid=1.
- WIDTH=8, shift in 0xA5 MSB first -> parallel_out=8'hA5 and word_valid=1 after the 8th edge. Shifting one more bit 1 gives 8'h4B.
